s27_scan_array: RTL and testbench

Parametrised successor to the single-instance s27 benchmark core. It replicates the s27 sequential function across CHANNELS independent channels and adds the following:
- an asynchronous active-low reset;
- a mux-D scan chain through every state flop;
- a per-array HOLD mode;
- a saturating counter of functional update cycles.

It is used as a scalable sequential test vehicle in the benchmark suite.

---
 rtl/s27_scan_array_pkg.sv | 30 +++
 rtl/s27_scan_array_if.sv | 28 ++
 rtl/s27_scan_array_core.sv | 69 ++++++
 rtl/s27_scan_array.sv | 60 ++++++
 tb/tb_s27_scan_array.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/s27_scan_array_pkg.sv
// Shared definitions for the s27 scan array: state width, reset value,
// per-channel chain bit positions and the update-mode decode.
package s27_pkg;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] STATE_RST = 3'b000;

  // Position of each state flop inside a channel's slice of the scan chain
  localparam int IDX_G5 = 0;
  localparam int IDX_G6 = 1;
  localparam int IDX_G7 = 2;

  typedef enum logic [1:0] {
    MODE_RESET,
    MODE_SCAN,
    MODE_HOLD,
    MODE_FUNC
  } mode_e;

  // Priority: reset, then scan shift, then hold, then functional update
  function automatic mode_e mode_of(input logic rn, input logic se, input logic hold);
    mode_e m;
    if (!rn)      m = MODE_RESET;
    else if (se)  m = MODE_SCAN;
    else if (hold) m = MODE_HOLD;
    else          m = MODE_FUNC;
    return m;
  endfunction

endpackage

// File: rtl/s27_scan_array_if.sv
// Bundled per-channel data, scan and mode signals of the s27 scan array.
interface s27_scan_array_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);

  logic [CHANNELS-1:0] G0;
  logic [CHANNELS-1:0] G1;
  logic [CHANNELS-1:0] G2;
  logic [CHANNELS-1:0] G3;
  logic                SE;
  logic                HOLD;
  logic                SI;
  logic [CHANNELS-1:0] G17;
  logic                SO;
  logic [CNT_W-1:0]    CYC;

  modport master (
    output G0, G1, G2, G3, SE, HOLD, SI,
    input  G17, SO, CYC
  );

  modport slave (
    input  G0, G1, G2, G3, SE, HOLD, SI,
    output G17, SO, CYC
  );

endinterface

// File: rtl/s27_scan_array_core.sv
// One s27 channel: combinational network, three negedge state flops with
// asynchronous clear, a scan mux on every flop and a hold enable.
module s27_core
  import s27_pkg::*;
(
  input  logic               CK,
  input  logic               RN,
  input  logic               SE,
  input  logic               HOLD,
  input  logic               SI,
  input  logic               G0,
  input  logic               G1,
  input  logic               G2,
  input  logic               G3,
  output logic               G17,
  output logic [STATE_W-1:0] state_q
);

  logic G5, G6, G7;
  logic G8, G9, G10, G11, G12, G13, G14, G15, G16;
  logic [STATE_W-1:0] func_d;
  logic [STATE_W-1:0] scan_d;
  mode_e              mode;

  assign G5 = state_q[IDX_G5];
  assign G6 = state_q[IDX_G6];
  assign G7 = state_q[IDX_G7];

  // s27 gate network and next-state / shift-state selection
  always_comb begin
    G14 = ~G0;
    G8  = G14 & G6;
    G12 = ~(G1 | G7);
    G15 = G12 | G8;
    G16 = G3 | G8;
    G9  = ~(G16 & G15);
    G11 = ~(G5 | G9);
    G10 = ~(G14 | G11);
    G13 = ~(G2 | G12);
    G17 = ~G11;

    func_d         = STATE_RST;
    func_d[IDX_G5] = G10;
    func_d[IDX_G6] = G11;
    func_d[IDX_G7] = G13;

    // Shift toward G7: SI -> G5 -> G6 -> G7
    scan_d         = STATE_RST;
    scan_d[IDX_G5] = SI;
    scan_d[IDX_G6] = G5;
    scan_d[IDX_G7] = G6;

    mode = mode_of(RN, SE, HOLD);
  end

  // State flops: async clear, then scan, hold or functional update
  always_ff @(negedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= STATE_RST;
    end else begin
      case (mode)
        MODE_SCAN: state_q <= scan_d;
        MODE_FUNC: state_q <= func_d;
        default:   state_q <= state_q;
      endcase
    end
  end

endmodule

// File: rtl/s27_scan_array.sv
// Array of CHANNELS independent s27 channels stitched into one scan chain,
// with a saturating count of functional update cycles.
module s27_scan_array
  import s27_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              GND,
  input  logic              VDD,
  s27_scan_array_if.slave   bus
);

  logic [CHANNELS:0]   chain;
  logic [CHANNELS-1:0] g17;
  logic [CNT_W-1:0]    cyc_q;
  logic                unused_pins;

  // Supply pins exist only for pin compatibility
  assign unused_pins = GND ^ VDD;

  assign chain[0] = bus.SI;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [STATE_W-1:0] st;

    s27_core u_core (
      .CK      (CK),
      .RN      (RN),
      .SE      (bus.SE),
      .HOLD    (bus.HOLD),
      .SI      (chain[i]),
      .G0      (bus.G0[i]),
      .G1      (bus.G1[i]),
      .G2      (bus.G2[i]),
      .G3      (bus.G3[i]),
      .G17     (g17[i]),
      .state_q (st)
    );

    // Each channel's G7 feeds the next channel's G5
    assign chain[i+1] = st[IDX_G7];
  end

  assign bus.G17 = g17;
  assign bus.SO  = chain[CHANNELS];
  assign bus.CYC = cyc_q;

  // Functional-cycle counter: counts only functional updates, sticks at all-ones
  always_ff @(negedge CK or negedge RN) begin
    if (!RN) begin
      cyc_q <= '0;
    end else if (mode_of(RN, bus.SE, bus.HOLD) == MODE_FUNC && cyc_q != {CNT_W{1'b1}}) begin
      cyc_q <= cyc_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_s27_scan_array.sv
// Directed bench for s27_scan_array: a 4-channel array and a 1-channel
// array with a 3-bit counter share clock and reset.
module tb_s27_scan_array;

  logic CK;
  logic RN;
  int   n_tests;
  int   n_fail;

  s27_scan_array_if #(.CHANNELS(4), .CNT_W(8)) bus_a ();
  s27_scan_array_if #(.CHANNELS(1), .CNT_W(3)) bus_b ();

  s27_scan_array #(.CHANNELS(4), .CNT_W(8)) dut_a (
    .CK  (CK),
    .RN  (RN),
    .GND (1'b0),
    .VDD (1'b1),
    .bus (bus_a)
  );

  s27_scan_array #(.CHANNELS(1), .CNT_W(3)) dut_b (
    .CK  (CK),
    .RN  (RN),
    .GND (1'b0),
    .VDD (1'b1),
    .bus (bus_b)
  );

  initial begin
    CK = 1'b1;
    forever #5 CK = ~CK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ch0 state as {G5,G6,G7}
  function automatic logic [2:0] st0();
    logic [2:0] s;
    s = dut_a.g_ch[0].st;
    return {s[0], s[1], s[2]};
  endfunction

  function automatic logic [2:0] st1();
    logic [2:0] s;
    s = dut_a.g_ch[1].st;
    return {s[0], s[1], s[2]};
  endfunction

  task automatic test_reset();
    RN = 1'b0;
    bus_a.G0 = 4'b0000; bus_a.G1 = 4'b0000; bus_a.G2 = 4'b0000; bus_a.G3 = 4'b0001;
    bus_a.SE = 1'b0; bus_a.HOLD = 1'b0; bus_a.SI = 1'b0;
    bus_b.G0 = 1'b0; bus_b.G1 = 1'b0; bus_b.G2 = 1'b0; bus_b.G3 = 1'b0;
    bus_b.SE = 1'b1; bus_b.HOLD = 1'b0; bus_b.SI = 1'b0;
    #12;
    n_tests++;
    if (bus_a.G17[0] !== 1'b0) begin
      n_fail++; $display("FAIL reset_g17_g3hi: got %b want 0", bus_a.G17[0]);
    end
    n_tests++;
    if (bus_a.SO !== 1'b0) begin
      n_fail++; $display("FAIL reset_so: got %b want 0", bus_a.SO);
    end
    n_tests++;
    if (bus_a.CYC !== 8'd0) begin
      n_fail++; $display("FAIL reset_cyc: got %0d want 0", bus_a.CYC);
    end
    #2 bus_a.G3 = 4'b0000;
    #1;
    n_tests++;
    if (bus_a.G17[0] !== 1'b1) begin
      n_fail++; $display("FAIL reset_g17_g3lo: got %b want 1", bus_a.G17[0]);
    end
  endtask

  task automatic test_functional();
    @(posedge CK);
    RN = 1'b1;
    bus_a.G0 = 4'b0001; bus_a.G1 = 4'b0000; bus_a.G2 = 4'b0000; bus_a.G3 = 4'b0001;
    #1;
    n_tests++;
    if (bus_a.G17[0] !== 1'b0) begin
      n_fail++; $display("FAIL func_g17_pre: got %b want 0", bus_a.G17[0]);
    end
    @(negedge CK); #1;
    n_tests++;
    if (st0() !== 3'b010) begin
      n_fail++; $display("FAIL func_state1: got %b want 010", st0());
    end
    n_tests++;
    if (bus_a.CYC !== 8'd1) begin
      n_fail++; $display("FAIL func_cyc1: got %0d want 1", bus_a.CYC);
    end
    @(posedge CK);
    bus_a.G0 = 4'b0000;
    @(negedge CK); #1;
    n_tests++;
    if (st0() !== 3'b010) begin
      n_fail++; $display("FAIL func_state2: got %b want 010", st0());
    end
    n_tests++;
    if (bus_a.G17[0] !== 1'b0) begin
      n_fail++; $display("FAIL func_g17_post: got %b want 0", bus_a.G17[0]);
    end
    n_tests++;
    if (bus_a.CYC !== 8'd2) begin
      n_fail++; $display("FAIL func_cyc2: got %0d want 2", bus_a.CYC);
    end
  endtask

  task automatic test_hold();
    // 12'hA00 shifted LSB first leaves ch0 {G5,G6,G7}=101 and ch1..ch3 at 000
    logic [11:0] w;
    logic [3:0]  vec [5];
    logic        g17_ch1 [5];
    w = 12'hA00;
    vec[0] = 4'b1000; vec[1] = 4'b1011; vec[2] = 4'b1100; vec[3] = 4'b0001; vec[4] = 4'b1110;
    g17_ch1[0] = 1'b0; g17_ch1[1] = 1'b1; g17_ch1[2] = 1'b0; g17_ch1[3] = 1'b1; g17_ch1[4] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge CK);
      bus_a.SE = 1'b1;
      bus_a.SI = w[k];
      @(negedge CK);
    end
    #1;
    n_tests++;
    if (st0() !== 3'b101) begin
      n_fail++; $display("FAIL hold_load_ch0: got %b want 101", st0());
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge CK);
      bus_a.SE = 1'b0;
      bus_a.HOLD = 1'b1;
      // vec bits are {G3,G2,G1,G0}
      bus_a.G0 = {4{vec[k][0]}}; bus_a.G1 = {4{vec[k][1]}};
      bus_a.G2 = {4{vec[k][2]}}; bus_a.G3 = {4{vec[k][3]}};
      @(negedge CK); #1;
      n_tests++;
      if (st0() !== 3'b101 || bus_a.CYC !== 8'd2) begin
        n_fail++; $display("FAIL hold_state[%0d]: got %b cyc %0d want 101 cyc 2", k, st0(), bus_a.CYC);
      end
      n_tests++;
      if (bus_a.G17[1] !== g17_ch1[k] || bus_a.G17[0] !== 1'b1) begin
        n_fail++; $display("FAIL hold_g17[%0d]: got ch1 %b ch0 %b want ch1 %b ch0 1", k, bus_a.G17[1], bus_a.G17[0], g17_ch1[k]);
      end
    end
    n_tests++;
    if (st1() !== 3'b000) begin
      n_fail++; $display("FAIL hold_ch1_state: got %b want 000", st1());
    end
  endtask

  task automatic test_scan_roundtrip();
    logic [11:0] w;
    w = 12'hA5C;
    for (int j = 1; j <= 24; j++) begin
      @(posedge CK);
      bus_a.SE = 1'b1;
      bus_a.HOLD = 1'b0;
      bus_a.SI = (j <= 12) ? w[j-1] : 1'b0;
      @(negedge CK); #1;
      if (j >= 12 && j <= 23) begin
        n_tests++;
        if (bus_a.SO !== w[j-12]) begin
          n_fail++; $display("FAIL scan_so[%0d]: got %b want %b", j-12, bus_a.SO, w[j-12]);
        end
      end
    end
    n_tests++;
    if (bus_a.CYC !== 8'd2) begin
      n_fail++; $display("FAIL scan_cyc: got %0d want 2", bus_a.CYC);
    end
  endtask

  task automatic test_saturation();
    logic [2:0] exp_cyc;
    @(posedge CK);
    bus_a.SE = 1'b0;
    bus_a.HOLD = 1'b1;
    // Single-channel chain: first shifted bit reaches SO after 3 shifts
    for (int j = 0; j < 3; j++) begin
      @(posedge CK);
      bus_b.SE = 1'b1;
      bus_b.SI = (j == 0);
      @(negedge CK);
    end
    #1;
    n_tests++;
    if (bus_b.SO !== 1'b1 || bus_b.CYC !== 3'd0) begin
      n_fail++; $display("FAIL single_chain_so: got so %b cyc %0d want so 1 cyc 0", bus_b.SO, bus_b.CYC);
    end
    exp_cyc = 3'd0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge CK);
      bus_b.SE = 1'b0;
      bus_b.HOLD = 1'b0;
      @(negedge CK); #1;
      if (exp_cyc != 3'd7) exp_cyc = exp_cyc + 3'd1;
      n_tests++;
      if (bus_b.CYC !== exp_cyc) begin
        n_fail++; $display("FAIL sat_cyc[%0d]: got %0d want %0d", k, bus_b.CYC, exp_cyc);
      end
    end
    n_tests++;
    if (bus_a.CYC !== 8'd2) begin
      n_fail++; $display("FAIL sat_main_cyc: got %0d want 2", bus_a.CYC);
    end
  endtask

  task automatic test_async_reset_mid_scan();
    for (int j = 0; j < 4; j++) begin
      @(posedge CK);
      bus_a.SE = 1'b1;
      bus_a.HOLD = 1'b0;
      bus_a.SI = 1'b1;
      @(negedge CK);
    end
    #1;
    n_tests++;
    if (st0() !== 3'b111) begin
      n_fail++; $display("FAIL arst_pre_state: got %b want 111", st0());
    end
    @(posedge CK);
    #2 RN = 1'b0;
    #1;
    n_tests++;
    if (st0() !== 3'b000 || st1() !== 3'b000 || bus_a.SO !== 1'b0 || bus_a.CYC !== 8'd0) begin
      n_fail++; $display("FAIL arst_immediate: got ch0 %b ch1 %b so %b cyc %0d want 000 000 0 0", st0(), st1(), bus_a.SO, bus_a.CYC);
    end
    @(negedge CK); #1;
    n_tests++;
    if (st0() !== 3'b000 || bus_a.CYC !== 8'd0) begin
      n_fail++; $display("FAIL arst_held: got ch0 %b cyc %0d want 000 0", st0(), bus_a.CYC);
    end
    @(posedge CK);
    RN = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      if (j > 1) @(posedge CK);
      bus_a.SI = 1'b1;
      @(negedge CK); #1;
      if (j == 1) begin
        n_tests++;
        if (st0() !== 3'b100) begin
          n_fail++; $display("FAIL arst_resume_first: got %b want 100", st0());
        end
      end
      if (j == 11) begin
        n_tests++;
        if (bus_a.SO !== 1'b0) begin
          n_fail++; $display("FAIL arst_resume_so11: got %b want 0", bus_a.SO);
        end
      end
      if (j == 12) begin
        n_tests++;
        if (bus_a.SO !== 1'b1 || bus_a.CYC !== 8'd0) begin
          n_fail++; $display("FAIL arst_resume_so12: got so %b cyc %0d want so 1 cyc 0", bus_a.SO, bus_a.CYC);
        end
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_functional();
    test_hold();
    test_scan_roundtrip();
    test_saturation();
    test_async_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
